// File: rtl/watch_run_ctrl.sv
// Stopwatch run-control sequencer: synchronises the four keys, detects rising
// edges and sequences the BCD counter's enable/clear/load and the lap capture.
module watch_run_ctrl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_start,
    input  logic       key_pause,
    input  logic       key_load,
    input  logic       key_lap,
    input  logic       cnt_ovf,
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic       cnt_load,
    output logic       lap_cap,
    output logic [1:0] state
);

    // state | meaning
    // IDLE  | cleared/preset, waiting for start; load key presets the counter
    // RUN   | counting; lap key captures, pause/start/overflow leave
    // PAUSE | counting suspended; pause resumes, start stops
    // STOP  | frozen after stop or wrap; start clears and returns to IDLE
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;
    localparam logic [1:0] ST_STOP  = 2'b11;

    localparam int NK     = 4;
    localparam int K_STRT = 0;
    localparam int K_PAUS = 1;
    localparam int K_LOAD = 2;
    localparam int K_LAP  = 3;

    logic [NK-1:0]                  key_raw;
    logic [NK-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
    logic [NK-1:0]                  sync_out;
    logic [NK-1:0]                  hist_q, hist_d;
    logic [NK-1:0]                  edge_q, edge_d;
    logic                           ovf_q, ovf_d;

    logic [1:0] state_q, state_d;
    logic       cnt_en_q, cnt_en_d;
    logic       cnt_clr_q, cnt_clr_d;
    logic       cnt_load_q, cnt_load_d;
    logic       lap_cap_q, lap_cap_d;

    assign key_raw = {key_lap, key_load, key_pause, key_start};

    always_comb begin
        for (int k = 0; k < NK; k++) begin
            sync_d[k]   = {sync_q[k][SYNC_STAGES-2:0], key_raw[k]};
            sync_out[k] = sync_q[k][SYNC_STAGES-1];
        end
        hist_d = sync_out;
        edge_d = sync_out & ~hist_q;
        ovf_d  = cnt_ovf;
    end

    // Synchroniser and history reset high so a key held through reset is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            hist_q <= '1;
            edge_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
            edge_q <= edge_d;
            ovf_q  <= ovf_d;
        end
    end

    // Each if/else chain encodes the event priority ovf > start > pause > load > lap.
    always_comb begin
        state_d    = state_q;
        cnt_clr_d  = 1'b0;
        cnt_load_d = 1'b0;
        lap_cap_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (edge_q[K_STRT]) begin
                    state_d = ST_RUN;
                end else if (edge_q[K_LOAD]) begin
                    cnt_load_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (ovf_q) begin
                    state_d = ST_STOP;
                end else if (edge_q[K_STRT]) begin
                    state_d = ST_STOP;
                end else if (edge_q[K_PAUS]) begin
                    state_d = ST_PAUSE;
                end else if (edge_q[K_LAP]) begin
                    lap_cap_d = 1'b1;
                end
            end
            ST_PAUSE: begin
                if (edge_q[K_STRT]) begin
                    state_d = ST_STOP;
                end else if (edge_q[K_PAUS]) begin
                    state_d = ST_RUN;
                end
            end
            ST_STOP: begin
                if (edge_q[K_STRT]) begin
                    state_d   = ST_IDLE;
                    cnt_clr_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        cnt_en_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_en_q   <= 1'b0;
            cnt_clr_q  <= 1'b0;
            cnt_load_q <= 1'b0;
            lap_cap_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_en_q   <= cnt_en_d;
            cnt_clr_q  <= cnt_clr_d;
            cnt_load_q <= cnt_load_d;
            lap_cap_q  <= lap_cap_d;
        end
    end

    assign state    = state_q;
    assign cnt_en   = cnt_en_q;
    assign cnt_clr  = cnt_clr_q;
    assign cnt_load = cnt_load_q;
    assign lap_cap  = lap_cap_q;

endmodule

// File: tb/tb_watch_run_ctrl.sv
// Scoreboard bench for watch_run_ctrl: a table-driven reference model predicts
// the outputs after every clock edge; a monitor compares on the falling edge.
module tb_watch_run_ctrl;

    localparam int S = 2;
    localparam int D = S + 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_start = 1'b0, key_pause = 1'b0, key_load = 1'b0, key_lap = 1'b0;
    logic       cnt_ovf = 1'b0;
    logic       cnt_en, cnt_clr, cnt_load, lap_cap;
    logic [1:0] state;

    int n_pass = 0;
    int n_total = 0;

    watch_run_ctrl #(.SYNC_STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n),
        .key_start(key_start), .key_pause(key_pause),
        .key_load(key_load), .key_lap(key_lap),
        .cnt_ovf(cnt_ovf),
        .cnt_en(cnt_en), .cnt_clr(cnt_clr), .cnt_load(cnt_load),
        .lap_cap(lap_cap), .state(state)
    );

    always #5 clk = ~clk;

    // Transition table: rows are states (00 IDLE, 01 RUN, 10 PAUSE, 11 STOP),
    // columns are events in priority order ovf, start, pause, load, lap.
    // -1 marks an event ignored in that state. Pulse: 0 none, 1 clr, 2 load, 3 lap.
    int next_tbl [4][5] = '{'{-1, 1, -1,  0, -1},
                            '{ 3, 3,  2, -1,  1},
                            '{-1, 3,  1, -1, -1},
                            '{-1, 0, -1, -1, -1}};
    int pulse_tbl [4][5] = '{'{0, 0, 0, 2, 0},
                             '{0, 0, 0, 0, 3},
                             '{0, 0, 0, 0, 0},
                             '{0, 1, 0, 0, 0}};

    bit         hist [4][D];
    bit         ovf_prev;
    int         m_state;
    int         m_pulse;
    logic [5:0] exp_q [$];

    function automatic logic [5:0] model_vec();
        logic [1:0] s;
        s = m_state[1:0];
        return {s, (m_state == 1), (m_pulse == 1), (m_pulse == 2), (m_pulse == 3)};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++)
                for (int j = 0; j < D; j++) hist[k][j] = 1'b1;
            ovf_prev = 1'b0;
            m_state  = 0;
            m_pulse  = 0;
            exp_q.delete();
            exp_q.push_back(model_vec());
        end else begin
            bit       ev [5];
            bit [3:0] kv;
            kv = {key_lap, key_load, key_pause, key_start};
            for (int k = 0; k < 4; k++) begin
                for (int j = D - 1; j > 0; j--) hist[k][j] = hist[k][j-1];
                hist[k][0] = kv[k];
            end
            // An event acts S+1 edges after the key is first sampled high.
            ev[0] = ovf_prev;
            for (int k = 0; k < 4; k++) ev[k+1] = hist[k][S+1] & ~hist[k][S+2];
            ovf_prev = cnt_ovf;
            m_pulse = 0;
            for (int p = 0; p < 5; p++) begin
                if (ev[p] && next_tbl[m_state][p] >= 0) begin
                    m_pulse = pulse_tbl[m_state][p];
                    m_state = next_tbl[m_state][p];
                    break;
                end
            end
            exp_q.push_back(model_vec());
        end
    end

    task automatic chk(input string name, input logic [5:0] got, input logic [5:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got state/en/clr/load/lap=%b required %b at %0t", name, got, want, $time);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [5:0] e;
            e = exp_q.pop_front();
            chk("outputs", {state, cnt_en, cnt_clr, cnt_load, lap_cap}, e);
            n_total++;
            if ($countones({cnt_clr, cnt_load, lap_cap}) <= 1) n_pass++;
            else $display("FAIL pulse_onehot: got clr/load/lap=%b required at most one high", {cnt_clr, cnt_load, lap_cap});
        end
    end

    task automatic press(input int which, input int hold, input int gap);
        @(posedge clk); #2;
        case (which)
            0: key_start = 1'b1;
            1: key_pause = 1'b1;
            2: key_load  = 1'b1;
            default: key_lap = 1'b1;
        endcase
        repeat (hold) @(posedge clk);
        #2;
        case (which)
            0: key_start = 1'b0;
            1: key_pause = 1'b0;
            2: key_load  = 1'b0;
            default: key_lap = 1'b0;
        endcase
        repeat (gap) @(posedge clk);
    endtask

    initial begin
        key_start = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #2 key_start = 1'b0;
        repeat (4) @(posedge clk);

        // start, pause, pause, start, start
        press(0, 3, 6); press(1, 3, 6); press(1, 3, 6); press(0, 3, 6); press(0, 3, 6);

        // load in IDLE, laps in RUN, ignored keys elsewhere
        press(3, 3, 6); press(2, 3, 6); press(0, 3, 6);
        for (int i = 0; i < 4; i++) press(3, 2, 5);
        press(2, 3, 6); press(1, 3, 6); press(3, 3, 6); press(2, 3, 6);
        press(1, 3, 6); press(0, 3, 6); press(0, 3, 6);

        // cnt_ovf coinciding with a start edge in RUN
        press(0, 3, 6);
        @(posedge clk); #2 key_start = 1'b1;
        @(posedge clk); @(posedge clk); #2 cnt_ovf = 1'b1;
        @(posedge clk); #2 cnt_ovf = 1'b0;
        repeat (3) @(posedge clk); #2 key_start = 1'b0;
        repeat (6) @(posedge clk);
        press(0, 3, 6);

        // pause and lap edges coinciding in RUN
        press(0, 3, 6);
        @(posedge clk); #2 key_pause = 1'b1; key_lap = 1'b1;
        repeat (4) @(posedge clk); #2 key_pause = 1'b0; key_lap = 1'b0;
        repeat (6) @(posedge clk);
        press(1, 3, 6); press(0, 3, 6); press(0, 3, 6);

        // reset while a cnt_load pulse is high
        begin
            bit seen;
            seen = 1'b0;
            @(posedge clk); #2 key_load = 1'b1;
            for (int i = 0; i < 10 && !seen; i++) begin
                @(posedge clk); #1;
                if (m_pulse == 2) seen = 1'b1;
            end
            n_total++;
            if (seen) n_pass++;
            else $display("FAIL load_pulse_wait: got no cnt_load prediction within 10 cycles required one");
            rst_n = 1'b0;
            #1;
            chk("reset_async", {state, cnt_en, cnt_clr, cnt_load, lap_cap}, 6'b000000);
            key_load = 1'b0;
            repeat (2) @(posedge clk);
            @(negedge clk) rst_n = 1'b1;
            repeat (3) @(posedge clk); #1;
            chk("after_reset", {state, cnt_en, cnt_clr, cnt_load, lap_cap}, 6'b000000);
        end

        // randomised phase
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #2;
            if ($urandom_range(0, 5) == 0) key_start = ~key_start;
            if ($urandom_range(0, 5) == 0) key_pause = ~key_pause;
            if ($urandom_range(0, 5) == 0) key_load  = ~key_load;
            if ($urandom_range(0, 5) == 0) key_lap   = ~key_lap;
            cnt_ovf = ($urandom_range(0, 15) == 0);
        end
        @(posedge clk); #2;
        key_start = 1'b0; key_pause = 1'b0; key_load = 1'b0; key_lap = 1'b0; cnt_ovf = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
